riscv_inst_msg_disasm: RTL and testbench
========================================

RISCV_INST_MSG_DISASM -- requirements
Module: riscv_InstMsgDisasm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk, input, 1, rising-edge clock.
REQ-003 reset, input, 1, asynchronous active-high reset.
REQ-004 msg, input, 32, RV32IM instruction word in standard field layout:
- funct7 [31:25], rs2 [24:20], rs1 [19:15], funct3 [14:12], rd [11:7], opcode [6:0].
REQ-005 dasm, output, 192, combinational 24-char ASCII disassembly; first char in [191:184]; left-justified, right-padded with spaces (0x20).
REQ-006 dasm_r, output, 192, dasm registered on clk.

Function
REQ-007 dasm SHALL be a pure combinational function of msg, with zero-cycle latency.
REQ-008 Mnemonic SHALL be lowercase, left-justified in a 7-char field padded with spaces, followed directly by the operands.
REQ-009 Operand formats:
- Registers: "r" plus two decimal digits (r00..r31).
- Separator: ", ".
- Immediates: "0x" plus lowercase hex, zero-padded to a fixed digit count per format.
REQ-010 R-type (opcode 0110011) format "rd, rs1, rs2":
- funct7=0000000: add sll slt sltu xor srl or and (funct3 000..111).
- funct7=0100000: sub (funct3 000), sra (funct3 101).
- funct7=0000001: mul mulh mulhsu mulhu div divu rem remu (funct3 000..111).
REQ-011 OP-IMM (opcode 0010011) format "rd, rs1, 0xIII", where III is msg[31:20] as 3 hex digits:
- addi slti sltiu xori ori andi by funct3 (000, 010, 011, 100, 110, 111).
REQ-012 Shifts format "rd, rs1, 0xSS", where SS is msg[24:20] as 2 hex digits:
- slli: funct3 001, funct7 0000000.
- srli: funct3 101, funct7 0000000.
- srai: funct3 101, funct7 0100000.
REQ-013 Loads (opcode 0000011) format "rd, 0xIII(rs1)": lb lh lw lbu lhu (funct3 000, 001, 010, 100, 101).
REQ-014 Stores (opcode 0100011) format "rs2, 0xIII(rs1)", where imm = {msg[31:25], msg[11:7]}: sb sh sw (funct3 000, 001, 010).
REQ-015 Branches (opcode 1100011) format "rs1, rs2, 0xIIII":
- 13-bit offset {msg[31], msg[7], msg[30:25], msg[11:8], 0} shown as 4 hex digits.
- beq bne blt bge bltu bgeu (funct3 000, 001, 100, 101, 110, 111).
REQ-016 lui (opcode 0110111) and auipc (opcode 0010111) format "rd, 0xIIIII", where IIIII is msg[31:12] as 5 hex digits.
REQ-017 jal (opcode 1101111) format "rd, 0xIIIIII":
- 21-bit offset {msg[31], msg[19:12], msg[20], msg[30:21], 0} shown as 6 hex digits.
REQ-018 jalr (opcode 1100111, funct3 000) SHALL use the OP-IMM format.
REQ-019 msg == 0x00000013 SHALL display "nop" and SHALL take priority over addi.
REQ-020 Any encoding not listed above, including an undefined funct3/funct7 combination, SHALL display "undefined".
REQ-021 Every string SHALL fit in 24 chars, and all unused trailing characters SHALL be spaces.
REQ-022 dasm_r SHALL load dasm on every rising clk edge while reset is low.

Reset
REQ-023 While reset is high, dasm_r SHALL be 24 spaces, asynchronously, regardless of clk.
REQ-024 Reset SHALL NOT affect dasm.
REQ-025 On the first rising edge after reset deasserts, dasm_r SHALL take the current dasm value.

Verification
REQ-026 msg=0x00300233 -> dasm "add    r04, r00, r03".
REQ-027 msg=0x8ad98793 -> dasm "addi   r15, r19, 0x8ad".
REQ-028 msg=0xdeadb8b7 -> dasm "lui    r17, 0xdeadb".
REQ-029 msg=0x00000013 -> dasm "nop"; msg=0xffffffff -> dasm "undefined".
REQ-030 Assert reset mid-run with no clk edge -> dasm_r is all spaces immediately; release reset, apply one clk edge -> dasm_r equals dasm.
REQ-031 Sweep all branch and M-extension funct3 values -> each mnemonic is exactly as listed in REQ-010 and REQ-015.

Source files
------------

// File: rtl/riscv_inst_msg_disasm.sv
`default_nettype none
// ============================================================================
// Module      : riscv_inst_msg_disasm
// Description : RV32IM instruction word disassembler. Produces a 24-character
//               left-justified, space-padded ASCII string combinationally,
//               plus a registered copy with asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_inst_msg_disasm (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  msg,
  output logic [191:0] dasm,
  output logic [191:0] dasm_r
);

  localparam logic [191:0] C_BLANK = {24{8'h20}};

  localparam logic [6:0] C_OP_R     = 7'b0110011;
  localparam logic [6:0] C_OP_IMM   = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;
  localparam logic [6:0] C_OP_BR    = 7'b1100011;
  localparam logic [6:0] C_OP_LUI   = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;
  localparam logic [6:0] C_OP_JALR  = 7'b1100111;

  // Operand layout selected by the decoder
  typedef enum logic [3:0] {
    FMT_UNDEF,
    FMT_NOP,
    FMT_R,
    FMT_IMM,
    FMT_SHIFT,
    FMT_LOAD,
    FMT_STORE,
    FMT_BR,
    FMT_U,
    FMT_JAL
  } fmt_e;

  // "rNN" with two decimal digits
  function automatic logic [23:0] reg_str(input logic [4:0] r);
    logic [4:0] t;
    logic [4:0] o;
    t = r / 5'd10;
    o = r % 5'd10;
    return {8'h72, 8'h30 + {3'b000, t}, 8'h30 + {3'b000, o}};
  endfunction

  // One lowercase hex digit
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [31:0] hex2(input logic [4:0] v);
    return {"0x", hexc({3'b000, v[4]}), hexc(v[3:0])};
  endfunction

  function automatic logic [39:0] hex3(input logic [11:0] v);
    return {"0x", hexc(v[11:8]), hexc(v[7:4]), hexc(v[3:0])};
  endfunction

  function automatic logic [47:0] hex4(input logic [12:0] v);
    return {"0x", hexc({3'b000, v[12]}), hexc(v[11:8]), hexc(v[7:4]), hexc(v[3:0])};
  endfunction

  function automatic logic [55:0] hex5(input logic [19:0] v);
    return {"0x", hexc(v[19:16]), hexc(v[15:12]), hexc(v[11:8]), hexc(v[7:4]),
            hexc(v[3:0])};
  endfunction

  function automatic logic [63:0] hex6(input logic [20:0] v);
    return {"0x", hexc({3'b000, v[20]}), hexc(v[19:16]), hexc(v[15:12]),
            hexc(v[11:8]), hexc(v[7:4]), hexc(v[3:0])};
  endfunction

  logic [6:0]   w_opcode;
  logic [2:0]   w_funct3;
  logic [6:0]   w_funct7;
  logic [23:0]  w_rd;
  logic [23:0]  w_rs1;
  logic [23:0]  w_rs2;
  logic [11:0]  w_imm_i;
  logic [11:0]  w_imm_s;
  logic [12:0]  w_imm_b;
  logic [20:0]  w_imm_j;
  fmt_e         w_fmt;
  logic [55:0]  w_mn;
  logic [191:0] dasm_d;
  logic [191:0] dasm_q;

  assign w_opcode = msg[6:0];
  assign w_funct3 = msg[14:12];
  assign w_funct7 = msg[31:25];
  assign w_rd     = reg_str(msg[11:7]);
  assign w_rs1    = reg_str(msg[19:15]);
  assign w_rs2    = reg_str(msg[24:20]);
  assign w_imm_i  = msg[31:20];
  assign w_imm_s  = {msg[31:25], msg[11:7]};
  assign w_imm_b  = {msg[31], msg[7], msg[30:25], msg[11:8], 1'b0};
  assign w_imm_j  = {msg[31], msg[19:12], msg[20], msg[30:21], 1'b0};

  // Decode opcode/funct fields into an operand layout and a 7-char mnemonic
  always_comb begin
    w_fmt = FMT_UNDEF;
    w_mn  = "       ";
    case (w_opcode)
      C_OP_R: begin
        w_fmt = FMT_R;
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000:  w_mn = "add    ";
            3'b001:  w_mn = "sll    ";
            3'b010:  w_mn = "slt    ";
            3'b011:  w_mn = "sltu   ";
            3'b100:  w_mn = "xor    ";
            3'b101:  w_mn = "srl    ";
            3'b110:  w_mn = "or     ";
            default: w_mn = "and    ";
          endcase
        end else if (w_funct7 == 7'b0100000) begin
          if (w_funct3 == 3'b000)      w_mn = "sub    ";
          else if (w_funct3 == 3'b101) w_mn = "sra    ";
          else                         w_fmt = FMT_UNDEF;
        end else if (w_funct7 == 7'b0000001) begin
          case (w_funct3)
            3'b000:  w_mn = "mul    ";
            3'b001:  w_mn = "mulh   ";
            3'b010:  w_mn = "mulhsu ";
            3'b011:  w_mn = "mulhu  ";
            3'b100:  w_mn = "div    ";
            3'b101:  w_mn = "divu   ";
            3'b110:  w_mn = "rem    ";
            default: w_mn = "remu   ";
          endcase
        end else begin
          w_fmt = FMT_UNDEF;
        end
      end
      C_OP_IMM: begin
        w_fmt = FMT_IMM;
        case (w_funct3)
          3'b000:  w_mn = "addi   ";
          3'b010:  w_mn = "slti   ";
          3'b011:  w_mn = "sltiu  ";
          3'b100:  w_mn = "xori   ";
          3'b110:  w_mn = "ori    ";
          3'b111:  w_mn = "andi   ";
          3'b001: begin
            w_fmt = (w_funct7 == 7'b0000000) ? FMT_SHIFT : FMT_UNDEF;
            w_mn  = "slli   ";
          end
          default: begin
            w_fmt = FMT_SHIFT;
            if (w_funct7 == 7'b0000000)      w_mn = "srli   ";
            else if (w_funct7 == 7'b0100000) w_mn = "srai   ";
            else                             w_fmt = FMT_UNDEF;
          end
        endcase
        // The canonical nop encoding overrides addi
        if (msg == 32'h0000_0013) w_fmt = FMT_NOP;
      end
      C_OP_LOAD: begin
        w_fmt = FMT_LOAD;
        case (w_funct3)
          3'b000:  w_mn = "lb     ";
          3'b001:  w_mn = "lh     ";
          3'b010:  w_mn = "lw     ";
          3'b100:  w_mn = "lbu    ";
          3'b101:  w_mn = "lhu    ";
          default: w_fmt = FMT_UNDEF;
        endcase
      end
      C_OP_STORE: begin
        w_fmt = FMT_STORE;
        case (w_funct3)
          3'b000:  w_mn = "sb     ";
          3'b001:  w_mn = "sh     ";
          3'b010:  w_mn = "sw     ";
          default: w_fmt = FMT_UNDEF;
        endcase
      end
      C_OP_BR: begin
        w_fmt = FMT_BR;
        case (w_funct3)
          3'b000:  w_mn = "beq    ";
          3'b001:  w_mn = "bne    ";
          3'b100:  w_mn = "blt    ";
          3'b101:  w_mn = "bge    ";
          3'b110:  w_mn = "bltu   ";
          3'b111:  w_mn = "bgeu   ";
          default: w_fmt = FMT_UNDEF;
        endcase
      end
      C_OP_LUI: begin
        w_fmt = FMT_U;
        w_mn  = "lui    ";
      end
      C_OP_AUIPC: begin
        w_fmt = FMT_U;
        w_mn  = "auipc  ";
      end
      C_OP_JAL: begin
        w_fmt = FMT_JAL;
        w_mn  = "jal    ";
      end
      C_OP_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_fmt = FMT_IMM;
          w_mn  = "jalr   ";
        end
      end
      default: w_fmt = FMT_UNDEF;
    endcase
  end

  // Assemble the padded 24-character string for the selected layout
  always_comb begin
    dasm_d = C_BLANK;
    case (w_fmt)
      FMT_NOP:   dasm_d = {"nop", {21{8'h20}}};
      FMT_R:     dasm_d = {w_mn, w_rd, ", ", w_rs1, ", ", w_rs2, {4{8'h20}}};
      FMT_IMM:   dasm_d = {w_mn, w_rd, ", ", w_rs1, ", ", hex3(w_imm_i), {2{8'h20}}};
      FMT_SHIFT: dasm_d = {w_mn, w_rd, ", ", w_rs1, ", ", hex2(msg[24:20]), {3{8'h20}}};
      FMT_LOAD:  dasm_d = {w_mn, w_rd, ", ", hex3(w_imm_i), "(", w_rs1, ")", {2{8'h20}}};
      FMT_STORE: dasm_d = {w_mn, w_rs2, ", ", hex3(w_imm_s), "(", w_rs1, ")", {2{8'h20}}};
      FMT_BR:    dasm_d = {w_mn, w_rs1, ", ", w_rs2, ", ", hex4(w_imm_b), 8'h20};
      FMT_U:     dasm_d = {w_mn, w_rd, ", ", hex5(msg[31:12]), {5{8'h20}}};
      FMT_JAL:   dasm_d = {w_mn, w_rd, ", ", hex6(w_imm_j), {4{8'h20}}};
      default:   dasm_d = {"undefined", {15{8'h20}}};
    endcase
  end

  assign dasm = dasm_d;

  // Registered copy; cleared to blanks asynchronously while reset is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dasm_q <= C_BLANK;
    else       dasm_q <= dasm_d;
  end

  assign dasm_r = dasm_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_inst_msg_disasm.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_inst_msg_disasm
// Description : Directed self-checking bench for riscv_inst_msg_disasm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_inst_msg_disasm;

  logic         clk;
  logic         reset;
  logic [31:0]  msg;
  logic [191:0] dasm;
  logic [191:0] dasm_r;

  int n_cmp;
  int n_bad;

  riscv_inst_msg_disasm dut (
    .clk    (clk),
    .reset  (reset),
    .msg    (msg),
    .dasm   (dasm),
    .dasm_r (dasm_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Left-justify a string into 24 chars, space padded
  function automatic logic [191:0] s2v(input string s);
    logic [191:0] r;
    r = {24{8'h20}};
    for (int i = 0; i < s.len() && i < 24; i++) r[191-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic string mpad(input string m);
    string s;
    s = m;
    while (s.len() < 7) s = {s, " "};
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=\"%s\" exp=\"%s\"", tag, got, exp);
    end
  endtask

  task automatic chk_msg(input string tag, input logic [31:0] m, input string exp);
    msg = m;
    #1;
    check_eq(tag, dasm, s2v(exp));
  endtask

  string br_mn [8];
  string m_mn  [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    msg   = 32'h0000_0013;
    br_mn = '{"beq", "bne", "", "", "blt", "bge", "bltu", "bgeu"};
    m_mn  = '{"mul", "mulh", "mulhsu", "mulhu", "div", "divu", "rem", "remu"};

    // Reset state of the registered output
    @(posedge clk); #1;
    check_eq("reset_dasm_r", dasm_r, s2v(""));
    check_eq("reset_dasm", dasm, s2v("nop"));
    @(negedge clk);
    reset = 1'b0;

    // Directed decode vectors
    chk_msg("add",      32'h0030_0233, "add    r04, r00, r03");
    chk_msg("addi",     32'h8ad9_8793, "addi   r15, r19, 0x8ad");
    chk_msg("lui",      32'hdead_b8b7, "lui    r17, 0xdeadb");
    chk_msg("nop",      32'h0000_0013, "nop");
    chk_msg("addi_r01", 32'h0000_0093, "addi   r01, r00, 0x000");
    chk_msg("all_ones", 32'hffff_ffff, "undefined");
    chk_msg("sub",      32'h4031_00b3, "sub    r01, r02, r03");
    chk_msg("r_undef",  32'h4031_10b3, "undefined");
    chk_msg("srai",     32'h41f3_5293, "srai   r05, r06, 0x1f");
    chk_msg("slli",     32'h0052_1193, "slli   r03, r04, 0x05");
    chk_msg("lw",       32'h0041_2503, "lw     r10, 0x004(r02)");
    chk_msg("sw",       32'h7ff0_afa3, "sw     r31, 0x7ff(r01)");
    chk_msg("auipc",    32'h1234_5117, "auipc  r02, 0x12345");
    chk_msg("jal_pos",  32'h7fff_f0ef, "jal    r01, 0x0ffffe");
    chk_msg("jal_top",  32'h8000_00ef, "jal    r01, 0x100000");
    chk_msg("jalr",     32'h0102_80e7, "jalr   r01, r05, 0x010");
    chk_msg("jalr_bad", 32'h0102_90e7, "undefined");

    // Branch funct3 sweep: rs1=r01, rs2=r02, offset 0x1008
    for (int f = 0; f < 8; f++) begin
      logic [31:0] m;
      m = 32'h8020_8463 | (32'(f) << 12);
      chk_msg($sformatf("br_f3_%0d", f), m,
              (br_mn[f] == "") ? "undefined" : {mpad(br_mn[f]), "r01, r02, 0x1008"});
    end

    // M-extension funct3 sweep: rd=r01, rs1=r02, rs2=r03
    for (int f = 0; f < 8; f++) begin
      logic [31:0] m;
      m = 32'h0231_00b3 | (32'(f) << 12);
      chk_msg($sformatf("m_f3_%0d", f), m, {mpad(m_mn[f]), "r01, r02, r03"});
    end

    // Register follows dasm on each edge
    msg = 32'h0030_0233;
    @(posedge clk); #1;
    check_eq("reg_load", dasm_r, s2v("add    r04, r00, r03"));

    // Asynchronous reset mid-cycle, no clock edge in between
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("async_reset", dasm_r, s2v(""));
    check_eq("dasm_in_reset", dasm, s2v("add    r04, r00, r03"));
    msg = 32'hdead_b8b7;
    #1;
    reset = 1'b0;
    #1;
    check_eq("held_after_release", dasm_r, s2v(""));
    @(posedge clk); #1;
    check_eq("first_edge_after_reset", dasm_r, s2v("lui    r17, 0xdeadb"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
